pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Receive-side counterpart of the LED PWM generator: samples a single asynchronous PWM line, measures high time and period in clk cycles, and recovers the duty value that produced it.
- Used for loop-back self-test of the RGB fade chain, and to read external PWM sources.
- Detects a line stuck high or stuck low, and flags periods that are off-nominal.

Parameters:
- PWM_INTERVAL, 1000: nominal PWM period in clk cycles.
- TIMEOUT_CYCLES, 2*PWM_INTERVAL: cycles without the expected edge before declaring the line stuck.
- PERIOD_TOL, 0: allowed absolute deviation of the measured period from PWM_INTERVAL before period_err is set.
- FILTER_LEN, 3: stability length used only when the optional feature is compiled in.
- Derived constant CW = $clog2(TIMEOUT_CYCLES+1): width of all counters and value outputs.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- pwm_in  in  1  PWM line; asynchronous to clk.
- duty_value  out  CW  measured high cycles of the last complete period.
- period_value  out  CW  measured cycles of the last complete period.
- valid  out  1  one-cycle pulse when duty_value/period_value update.
- period_err  out  1  updated with valid; 1 if |period_value − PWM_INTERVAL| > PERIOD_TOL.
- stuck_high  out  1  level; the line has been high for ≥ TIMEOUT_CYCLES.
- stuck_low  out  1  level; the line has been low for ≥ TIMEOUT_CYCLES.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, counters 0, synchroniser flops 0.
- Input path: 2-flop synchroniser, then edge detect against the previous synced value.
  - A rise or fall flag asserts 3 clk edges after pwm_in is first sampled at the new level.
  - Latency is identical for both edges, so measured widths are exact.
- States: IDLE, HIGH, LOW, STUCK.
- IDLE:
  - cnt increments each cycle, saturating at TIMEOUT_CYCLES.
  - Rise: hi_cnt←1, per_cnt←1, go to HIGH. No output is published.
  - cnt reaches TIMEOUT_CYCLES: set stuck_high or stuck_low from the synced level, go to STUCK.
- HIGH:
  - Each cycle: hi_cnt++, per_cnt++.
  - Fall: per_cnt++, hi_cnt held, go to LOW.
- LOW:
  - Each cycle: per_cnt++.
  - Rise: publish duty_value←hi_cnt, period_value←per_cnt, valid←1, period_err computed. Then hi_cnt←1, per_cnt←1, stay on to HIGH.
- Worked example: high 300 cycles, period 1000 gives duty_value=300, period_value=1000.
- Timeout in HIGH or LOW (per_cnt == TIMEOUT_CYCLES with no edge that cycle):
  - Publish valid=1, period_err=1, period_value=0.
  - HIGH: duty_value=PWM_INTERVAL, stuck_high=1.
  - LOW: duty_value=0, stuck_low=1.
  - Go to STUCK.
- STUCK:
  - Counters frozen; stuck flag held.
  - Next rise: clear both stuck flags, hi_cnt←1, per_cnt←1, go to HIGH (no publish).
  - A fall in STUCK is ignored apart from level tracking.
- Simultaneous events: an edge and timeout in the same cycle → the edge wins and the timeout is discarded.
- Counters never wrap; a timeout always fires first.
- duty_value and period_value hold their last published value between valid pulses.
- Reset mid-period: everything cleared; the next complete period is not published until one full rise-to-rise interval has been seen.

Optional Feature:
- Macro PWM_CAPTURE_GLITCH_FILTER_EN.
- Defined:
  - The synced signal feeds a FILTER_LEN-cycle stability filter. The filtered level changes only after FILTER_LEN consecutive identical samples.
  - Pulses shorter than FILTER_LEN cycles are dropped.
  - Edge latency grows by FILTER_LEN cycles for both edges, so widths stay exact for pulses ≥ FILTER_LEN.
- Undefined: no filter; every synced transition is an edge.

Decomposition:
- Package pwm_capture_pkg:
  - state enum (IDLE, HIGH, LOW, STUCK).
  - function computing counter width from TIMEOUT_CYCLES.
- Sub-module pwm_in_sync holds the synchroniser, optional glitch filter and rise/fall pulse outputs.
- The FSM, counters and output registers stay in pwm_capture.

Test Plan:
1. Reset, then drive 300-high/700-low for 3 periods → 2 valid pulses, duty_value=300, period_value=1000, period_err=0. No publish for the first period.
2. Duty 0 (line low 2000+ cycles after reset) → stuck_low=1 at IDLE timeout, no valid. Then a normal 500/500 pattern → stuck_low clears on the first rise, then duty 500 is published.
3. Duty full (high 2000 cycles mid-operation) → valid with duty_value=1000, period_value=0, period_err=1, stuck_high=1. The flag clears on the next rise.
4. Period 1005 with PERIOD_TOL=0 → period_err=1, period_value=1005. Repeat with PERIOD_TOL=5 → period_err=0.
5. Assert rst_n low during HIGH with hi_cnt=150 → outputs 0 immediately (async). After release, the first publish occurs only after a full period.
6. With PWM_CAPTURE_GLITCH_FILTER_EN and FILTER_LEN=3: a 2-cycle low glitch inside a 300-cycle high → duty 300, one valid. Without the macro → the glitch splits the period and a short period is published with period_err=1.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared state encoding and width helper for the PWM capture block
package pwm_capture_pkg;

   // Capture FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HIGH  = 2'd1,
      LOW   = 2'd2,
      STUCK = 2'd3
   } state_t;

   // Clock edges after reset release during which the input pipeline still holds
   // reset values; edges seen in that window are not real line transitions.
   localparam int SYNC_PRIME_LEN = 4;

   // Width needed to hold any count up to and including the timeout.
   function automatic int calc_cw(input int timeout_cycles);
      return $clog2(timeout_cycles + 1);
   endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// rtl/pwm_in_sync.sv - PWM input synchroniser, optional glitch filter (PWM_CAPTURE_GLITCH_FILTER_EN), rise/fall pulses
module pwm_in_sync
   import pwm_capture_pkg::*;
#(
   parameter int FILTER_LEN = 3
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_pwm,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic       r_sync1;
   logic       r_sync2;
   logic       r_prev;
   logic       r_rise;
   logic       r_fall;
   logic [2:0] r_prime;
   logic       w_primed;
   logic       w_level;

   assign w_primed = (r_prime == 3'(SYNC_PRIME_LEN));

   // Two-flop synchroniser plus a short priming counter after reset release
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prime <= '0;
      end else begin
         r_sync1 <= i_pwm;
         r_sync2 <= r_sync1;
         if (!w_primed) begin
            r_prime <= r_prime + 3'd1;
         end
      end
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int FW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

   logic          r_filt;
   logic [FW-1:0] r_fcnt;

   // Filtered level follows the synced line only after FILTER_LEN identical differing samples
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_filt <= 1'b0;
         r_fcnt <= '0;
      end else if (!w_primed) begin
         r_filt <= r_sync2;
         r_fcnt <= '0;
      end else if (r_sync2 == r_filt) begin
         r_fcnt <= '0;
      end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
         r_filt <= r_sync2;
         r_fcnt <= '0;
      end else begin
         r_fcnt <= r_fcnt + 1'b1;
      end
   end

   assign w_level = r_filt;
`else
   assign w_level = r_sync2;
`endif

   // Registered edge pulses; a line already high at reset release is not reported as a rise
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prev <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_prev <= w_level;
         r_rise <= w_primed & w_level & ~r_prev;
         r_fall <= w_primed & ~w_level & r_prev;
      end
   end

   assign o_level = w_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM capture: high time, period, stuck-line and off-nominal period detection (PWM_CAPTURE_GLITCH_FILTER_EN adds an input glitch filter)
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int  PWM_INTERVAL   = 1000,
   parameter int  TIMEOUT_CYCLES = 2 * PWM_INTERVAL,
   parameter int  PERIOD_TOL     = 0,
   parameter int  FILTER_LEN     = 3,
   localparam int CW             = calc_cw(TIMEOUT_CYCLES)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_pwm_in,
   output logic [CW-1:0] o_duty_value,
   output logic [CW-1:0] o_period_value,
   output logic          o_valid,
   output logic          o_period_err,
   output logic          o_stuck_high,
   output logic          o_stuck_low
);

   localparam logic [CW-1:0] L_TIMEOUT  = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] L_INTERVAL = CW'(PWM_INTERVAL);
   localparam logic [CW-1:0] L_TOL      = CW'(PERIOD_TOL);

   state_t        r_state;
   logic [CW-1:0] r_idle_cnt;
   logic [CW-1:0] r_hi_cnt;
   logic [CW-1:0] r_per_cnt;
   logic [CW-1:0] r_duty;
   logic [CW-1:0] r_period;
   logic          r_valid;
   logic          r_period_err;
   logic          r_stuck_high;
   logic          r_stuck_low;

   logic          w_level;
   logic          w_rise;
   logic          w_fall;
   logic [CW-1:0] w_diff;
   logic          w_per_err;

   pwm_in_sync #(
      .FILTER_LEN (FILTER_LEN)
   ) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_pwm   (i_pwm_in),
      .o_level (w_level),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   // Absolute deviation of the running period count from nominal
   always_comb begin
      w_diff    = (r_per_cnt >= L_INTERVAL) ? (r_per_cnt - L_INTERVAL) : (L_INTERVAL - r_per_cnt);
      w_per_err = (w_diff > L_TOL);
   end

   // Capture FSM: counts high/period cycles, publishes on rise, flags stuck lines on timeout
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_idle_cnt   <= '0;
         r_hi_cnt     <= '0;
         r_per_cnt    <= '0;
         r_duty       <= '0;
         r_period     <= '0;
         r_valid      <= 1'b0;
         r_period_err <= 1'b0;
         r_stuck_high <= 1'b0;
         r_stuck_low  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_rise) begin
                  r_hi_cnt  <= CW'(1);
                  r_per_cnt <= CW'(1);
                  r_state   <= HIGH;
               end else if (r_idle_cnt == L_TIMEOUT) begin
                  r_stuck_high <= w_level;
                  r_stuck_low  <= ~w_level;
                  r_state      <= STUCK;
               end else begin
                  r_idle_cnt <= r_idle_cnt + 1'b1;
               end
            end
            HIGH: begin
               if (w_fall) begin
                  r_per_cnt <= r_per_cnt + 1'b1;
                  r_state   <= LOW;
               end else if (r_per_cnt == L_TIMEOUT) begin
                  r_duty       <= L_INTERVAL;
                  r_period     <= '0;
                  r_valid      <= 1'b1;
                  r_period_err <= 1'b1;
                  r_stuck_high <= 1'b1;
                  r_state      <= STUCK;
               end else begin
                  r_hi_cnt  <= r_hi_cnt + 1'b1;
                  r_per_cnt <= r_per_cnt + 1'b1;
               end
            end
            LOW: begin
               if (w_rise) begin
                  r_duty       <= r_hi_cnt;
                  r_period     <= r_per_cnt;
                  r_valid      <= 1'b1;
                  r_period_err <= w_per_err;
                  r_hi_cnt     <= CW'(1);
                  r_per_cnt    <= CW'(1);
                  r_state      <= HIGH;
               end else if (r_per_cnt == L_TIMEOUT) begin
                  r_duty       <= '0;
                  r_period     <= '0;
                  r_valid      <= 1'b1;
                  r_period_err <= 1'b1;
                  r_stuck_low  <= 1'b1;
                  r_state      <= STUCK;
               end else begin
                  r_per_cnt <= r_per_cnt + 1'b1;
               end
            end
            STUCK: begin
               if (w_rise) begin
                  r_stuck_high <= 1'b0;
                  r_stuck_low  <= 1'b0;
                  r_hi_cnt     <= CW'(1);
                  r_per_cnt    <= CW'(1);
                  r_state      <= HIGH;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_duty_value   = r_duty;
   assign o_period_value = r_period;
   assign o_valid        = r_valid;
   assign o_period_err   = r_period_err;
   assign o_stuck_high   = r_stuck_high;
   assign o_stuck_low    = r_stuck_low;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture (expectations follow PWM_CAPTURE_GLITCH_FILTER_EN)
module tb_pwm_capture;

   localparam int CW = $clog2(2 * 1000 + 1);

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          pwm_in = 1'b0;

   logic [CW-1:0] d0_duty, d0_period;
   logic          d0_valid, d0_err, d0_sh, d0_sl;
   logic [CW-1:0] d5_duty, d5_period;
   logic          d5_valid, d5_err, d5_sh, d5_sl;

   typedef struct {
      int duty;
      int period;
      bit err0;
      bit err5;
   } exp_t;

   typedef struct {
      int hi;
      int lo;
      int duty;
      int period;
      bit err0;
      bit err5;
   } vec_t;

   exp_t q0[$];
   exp_t q5[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pwm_capture #(
      .PWM_INTERVAL (1000),
      .PERIOD_TOL   (0)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_pwm_in       (pwm_in),
      .o_duty_value   (d0_duty),
      .o_period_value (d0_period),
      .o_valid        (d0_valid),
      .o_period_err   (d0_err),
      .o_stuck_high   (d0_sh),
      .o_stuck_low    (d0_sl)
   );

   pwm_capture #(
      .PWM_INTERVAL (1000),
      .PERIOD_TOL   (5)
   ) dut_tol5 (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_pwm_in       (pwm_in),
      .o_duty_value   (d5_duty),
      .o_period_value (d5_period),
      .o_valid        (d5_valid),
      .o_period_err   (d5_err),
      .o_stuck_high   (d5_sh),
      .o_stuck_low    (d5_sl)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic push(input int duty, input int period, input bit e0, input bit e5);
      exp_t e;
      e.duty   = duty;
      e.period = period;
      e.err0   = e0;
      e.err5   = e5;
      q0.push_back(e);
      q5.push_back(e);
   endtask

   // Scoreboard pop on every valid pulse of either instance
   task automatic sample();
      exp_t e;
      if (d0_valid) begin
         if (q0.size() == 0) begin
            chk("unexpected valid tol0", 1, 0);
         end else begin
            e = q0.pop_front();
            chk("duty tol0", 32'(d0_duty), e.duty);
            chk("period tol0", 32'(d0_period), e.period);
            chk("period_err tol0", 32'(d0_err), 32'(e.err0));
         end
      end
      if (d5_valid) begin
         if (q5.size() == 0) begin
            chk("unexpected valid tol5", 1, 0);
         end else begin
            e = q5.pop_front();
            chk("duty tol5", 32'(d5_duty), e.duty);
            chk("period tol5", 32'(d5_period), e.period);
            chk("period_err tol5", 32'(d5_err), 32'(e.err5));
         end
      end
   endtask

   // Hold the line at lvl for n clocks; inputs change 1 time unit after posedge
   task automatic hold(input logic lvl, input int n);
      pwm_in = lvl;
      repeat (n) begin
         @(negedge clk);
         sample();
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      vec_t vecs [8];
      vecs[0] = '{hi: 300, lo: 700, duty: 300, period: 1000, err0: 1'b0, err5: 1'b0};
      vecs[1] = '{hi: 300, lo: 700, duty: 300, period: 1000, err0: 1'b0, err5: 1'b0};
      vecs[2] = '{hi: 300, lo: 700, duty: 300, period: 1000, err0: 1'b0, err5: 1'b0};
      vecs[3] = '{hi: 500, lo: 500, duty: 500, period: 1000, err0: 1'b0, err5: 1'b0};
      vecs[4] = '{hi: 300, lo: 705, duty: 300, period: 1005, err0: 1'b1, err5: 1'b0};
      vecs[5] = '{hi: 100, lo: 903, duty: 100, period: 1003, err0: 1'b1, err5: 1'b0};
      vecs[6] = '{hi: 700, lo: 294, duty: 700, period: 994,  err0: 1'b1, err5: 1'b1};
      vecs[7] = '{hi: 3,   lo: 997, duty: 3,   period: 1000, err0: 1'b0, err5: 1'b0};

      rst_n  = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset duty", 32'(d0_duty), 0);
      chk("reset period", 32'(d0_period), 0);
      chk("reset valid", 32'(d0_valid), 0);
      chk("reset period_err", 32'(d0_err), 0);
      chk("reset stuck_high", 32'(d0_sh), 0);
      chk("reset stuck_low", 32'(d0_sl), 0);
      chk("reset stuck_low tol5", 32'(d5_sl), 0);
      rst_n = 1'b1;

      // Line low from reset: stuck_low only once the idle timeout expires
      hold(1'b0, 1990);
      chk("stuck_low before timeout", 32'(d0_sl), 0);
      hold(1'b0, 20);
      chk("stuck_low after timeout", 32'(d0_sl), 1);
      chk("stuck_low after timeout tol5", 32'(d5_sl), 1);
      chk("stuck_high while low", 32'(d0_sh), 0);

      // Table of periods; each rise publishes the previous vector
      for (int i = 0; i < 8; i++) begin
         if (i > 0) push(vecs[i-1].duty, vecs[i-1].period, vecs[i-1].err0, vecs[i-1].err5);
         hold(1'b1, vecs[i].hi);
         if (i == 0) chk("stuck_low cleared by rise", 32'(d0_sl), 0);
         hold(1'b0, vecs[i].lo);
      end

      // Final rise publishes the last vector, then the line sticks high
      push(vecs[7].duty, vecs[7].period, vecs[7].err0, vecs[7].err5);
      push(1000, 0, 1'b1, 1'b1);
      hold(1'b1, 1990);
      chk("stuck_high before timeout", 32'(d0_sh), 0);
      hold(1'b1, 20);
      chk("stuck_high after timeout", 32'(d0_sh), 1);
      chk("stuck_high after timeout tol5", 32'(d5_sh), 1);
      hold(1'b0, 100);
      chk("stuck_high held over fall", 32'(d0_sh), 1);
      chk("stuck_low not set by fall", 32'(d0_sl), 0);
      hold(1'b1, 20);
      chk("stuck_high cleared by rise", 32'(d0_sh), 0);
      hold(1'b1, 130);

      // Asynchronous reset in the middle of a high phase
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset duty", 32'(d0_duty), 0);
      chk("async reset period_err", 32'(d0_err), 0);
      chk("async reset stuck_high", 32'(d0_sh), 0);
      chk("async reset duty tol5", 32'(d5_duty), 0);
      @(posedge clk);
      #1;
      hold(1'b1, 4);
      rst_n = 1'b1;
      hold(1'b1, 150);
      hold(1'b0, 700);
      hold(1'b1, 300);
      hold(1'b0, 700);

      // Two-cycle low glitch inside a 300-cycle high phase
      push(300, 1000, 1'b0, 1'b0);
      hold(1'b1, 100);
      hold(1'b0, 2);
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
      push(100, 102, 1'b1, 1'b1);
`endif
      hold(1'b1, 198);
      hold(1'b0, 700);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      push(300, 1000, 1'b0, 1'b0);
`else
      push(198, 898, 1'b1, 1'b1);
`endif
      hold(1'b1, 50);
      hold(1'b0, 30);

      chk("scoreboard drained tol0", q0.size(), 0);
      chk("scoreboard drained tol5", q5.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
